// File: rtl/oifs_tx_pattern_gen.sv
// Multi-channel test-pattern source for the OIFS TX framer input: counter, PRBS or
// walking-one words, round-robin over channels, paced back-to-back or one per PERIOD.
module oifs_tx_pattern_gen #(
  parameter int                DATA_W    = 8,
  parameter int                CHANNELS  = 2,
  parameter string             MODE      = "PERIODIC",
  parameter int                PERIOD    = 99_000_000,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
  parameter int                DROP_W    = 16,
  localparam int               CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_enable,
  input  logic [1:0]        i_pattern,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CH_W-1:0]   o_channel,
  input  logic              i_ready,
  output logic              o_overrun,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam bit FULL = (MODE == "FULL_SPEED");
  localparam int TW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int NW   = 1 << CH_W;

  if ((MODE != "PERIODIC") && (MODE != "FULL_SPEED")) begin : g_mode_check
    $error("oifs_tx_pattern_gen: MODE must be \"PERIODIC\" or \"FULL_SPEED\"");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND} state_t;

  function automatic logic [DATA_W-1:0] seed_word(input logic [1:0] pat, input int k);
    case (pat)
      2'd1:    seed_word = DATA_W'(k + 1);
      2'd2:    seed_word = {{(DATA_W-1){1'b0}}, 1'b1};
      default: seed_word = '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] step_word(input logic [1:0] pat,
                                                  input logic [DATA_W-1:0] w);
    case (pat)
      2'd1:    step_word = (w >> 1) ^ (w[0] ? LFSR_TAPS : {DATA_W{1'b0}});
      2'd2:    step_word = {w[DATA_W-2:0], w[DATA_W-1]};
      default: step_word = w + DATA_W'(1);
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          pat_q, pat_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [DATA_W-1:0]   words_q [NW];
  logic [DATA_W-1:0]   words_d [NW];
  logic                tick_s;
  logic                xfer_s;

  assign tick_s = FULL ? 1'b0 : (tick_cnt_q == TW'(PERIOD - 1));
  assign xfer_s = valid_q & i_ready;

  // Next-state, word generation, pacing and drop accounting.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    chan_d     = chan_q;
    data_d     = data_q;
    overrun_d  = 1'b0;
    drop_d     = drop_q;
    words_d    = words_q;
    if (state_q == ST_IDLE) begin
      tick_cnt_d = '0;
    end else if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          pat_d = i_pattern;
          for (int k = 0; k < NW; k++) begin
            words_d[k] = seed_word(i_pattern, k);
          end
          chan_d  = '0;
          data_d  = seed_word(i_pattern, 0);
          state_d = FULL ? ST_SEND : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SEND: begin
        if (xfer_s) begin
          words_d[chan_q] = step_word(pat_q, words_q[chan_q]);
          chan_d = (chan_q == CH_W'(CHANNELS - 1)) ? '0 : chan_q + CH_W'(1);
          data_d = words_d[chan_d];
          if (!i_enable) begin
            state_d = ST_IDLE;
          end else if (FULL || tick_s) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (tick_s) begin
          // The pending word stays; the new tick is the one that is lost.
          overrun_d = 1'b1;
          drop_d    = (drop_q != {DROP_W{1'b1}}) ? drop_q + DROP_W'(1) : drop_q;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_SEND);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= ST_IDLE;
      pat_q      <= 2'd0;
      chan_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      drop_q     <= '0;
      tick_cnt_q <= '0;
      for (int k = 0; k < NW; k++) begin
        words_q[k] <= seed_word(2'd0, k);
      end
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      chan_q     <= chan_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      drop_q     <= drop_d;
      tick_cnt_q <= tick_cnt_d;
      words_q    <= words_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_channel  = chan_q;
  assign o_overrun  = overrun_q;
  assign o_drop_cnt = drop_q;

endmodule
